// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider: RISC-V M-extension divide ops
// and the divider FSM state type.
package div_seq_pkg;

  typedef logic [1:0] op_t;
  localparam op_t OP_DIV  = 2'd0;
  localparam op_t OP_DIVU = 2'd1;
  localparam op_t OP_REM  = 2'd2;
  localparam op_t OP_REMU = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIX  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic logic is_signed_op(input op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the pipeline (master) and the divider (slave).
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  op_t             op;
  logic            is_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, op, is_word, dividend, divisor, flush, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, op, is_word, dividend, divisor, flush, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[XLEN];
  assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 divider for DIV/DIVU/REM/REMU and their W forms; owns the
// FSM, iteration counter, special-case handling and sign fix-up.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  div_seq_if.slave     bus
);
  localparam int CW = $clog2(XLEN + 1);

  state_t          r_state;
  op_t             r_op;
  logic            r_word;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_dvsr;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;

  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic w,
                                             input logic s);
    if (!w) return v;
    return s ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operands as seen at acceptance, already extended to the op width.
  logic            w_accept;
  logic            w_req_signed;
  logic [XLEN-1:0] w_ext_a;
  logic [XLEN-1:0] w_ext_b;
  logic [XLEN-1:0] w_mag_a;

  assign w_accept     = bus.req_valid && (r_state == S_IDLE) && !bus.flush;
  assign w_req_signed = is_signed_op(bus.op);
  assign w_ext_a      = ext_op(bus.dividend, bus.is_word, w_req_signed);
  assign w_ext_b      = ext_op(bus.divisor, bus.is_word, w_req_signed);
  assign w_mag_a      = mag(w_ext_a, w_req_signed);

  // Quantities derived from the latched operation.
  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_min;
  logic [CW-1:0]   w_last;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_step_rem;
  logic            w_qbit;

  assign w_signed   = is_signed_op(r_op);
  assign w_neg_a    = w_signed && r_a[XLEN-1];
  assign w_neg_b    = w_signed && r_b[XLEN-1];
  assign w_div_zero = (r_b == '0);
  assign w_min      = r_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_ovf      = w_signed && (r_a == w_min) && (r_b == '1);
  assign w_last     = r_word ? CW'(31) : CW'(XLEN - 1);
  assign w_spec_res = word_fix(is_rem_op(r_op) ? (w_div_zero ? r_a : '0)
                                               : (w_div_zero ? '1 : r_a), r_word);
  assign w_quo_fix  = (w_neg_a ^ w_neg_b) ? -r_quo : r_quo;
  assign w_rem_fix  = w_neg_a ? -r_rem : r_rem;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[XLEN-1]),
    .i_divisor (r_dvsr),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  // NOTE: datapath registers are reset along with the FSM so no stale operand
  // or result survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_DIV;
      r_word   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.op;
          r_word  <= bus.is_word;
          r_a     <= w_ext_a;
          r_b     <= w_ext_b;
          r_dvsr  <= mag(w_ext_b, w_req_signed);
          r_quo   <= bus.is_word ? {w_mag_a[XLEN-33:0], 32'b0} : w_mag_a;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= S_CALC;
        end
        S_CALC: if (r_cnt == '0 && (w_div_zero || w_ovf)) begin
          r_result <= w_spec_res;
          r_state  <= S_DONE;
        end else begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= word_fix(is_rem_op(r_op) ? w_rem_fix : w_quo_fix, r_word);
          r_state  <= S_DONE;
        end
        S_DONE: if (bus.resp_ready) begin
          r_result <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = (r_state == S_DONE);
  assign bus.result     = (r_state == S_DONE) ? r_result : '0;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, special cases, flush, stall
// and reset behaviour against hand-computed values.
module tb_div_seq;
  import div_seq_pkg::*;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  div_seq_if #(.XLEN(XLEN)) bus ();

  div_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for the accepting edge, then scramble the inputs.
  task automatic start(input op_t op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.op        = op;
    bus.is_word   = w;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.op        = ~op;
    bus.is_word   = ~w;
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
  endtask

  // Called in cycle T+1; returns the cycle index (relative to T) of resp_valid.
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input op_t op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input int exp_lat, input logic [63:0] exp);
    int lat;
    start(op, w, a, b);
    wait_resp(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, bus.result, exp);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " idle"}, {62'b0, bus.busy, bus.resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    logic seen;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.op         = OP_DIV;
    bus.is_word    = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    check("reset busy", {63'b0, bus.busy}, 64'd0);
    check("reset result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset req_ready", {63'b0, bus.req_ready}, 64'd1);

    run("divu 100/7", OP_DIVU, 1'b0, 64'd100, 64'd7, 66, 64'd14);
    run("remu 100/7", OP_REMU, 1'b0, 64'd100, 64'd7, 66, 64'd2);
    run("div -7/2", OP_DIV, 1'b0, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);
    run("rem -7/2", OP_REM, 1'b0, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
    run("rem 7/-2", OP_REM, 1'b0, 64'd7, -64'sd2, 66, 64'd1);
    run("div 5/0", OP_DIV, 1'b0, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    run("rem 5/0", OP_REM, 1'b0, 64'd5, 64'd0, 2, 64'd5);
    run("div ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
        64'h8000_0000_0000_0000);
    run("divw ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
        64'hFFFF_FFFF_8000_0000);
    run("divuw max/1", OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0001, 34,
        64'hFFFF_FFFF_FFFF_FFFF);
    run("remw -7/2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFF);
    run("remuw 5/0", OP_REMU, 1'b1, 64'hFFFF_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 2, 64'd5);

    // Request in IDLE together with flush is dropped.
    bus.op = OP_DIVU; bus.is_word = 1'b0; bus.dividend = 64'd9; bus.divisor = 64'd3;
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush+req ignored busy", {63'b0, bus.busy}, 64'd0);

    // Flush during CALC at T+10.
    start(OP_DIV, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    #1;
    check("calc result gated", bus.result, 64'd0);
    check("calc busy", {63'b0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush idle", {61'b0, bus.busy, bus.resp_valid, bus.req_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check("flush no resp", {63'b0, seen}, 64'd0);
    run("div after flush", OP_DIV, 1'b0, 64'd1000, 64'd3, 66, 64'd333);

    // Consumer stall, then a request waiting at the response handshake.
    start(OP_DIVU, 1'b0, 64'd100, 64'd7);
    wait_resp(lat);
    check("stall latency", 64'(lat), 64'd66);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall hold flags", {62'b0, bus.busy, bus.resp_valid}, 64'd3);
      check("stall hold result", bus.result, 64'd14);
    end
    bus.op = OP_DIVU; bus.is_word = 1'b0; bus.dividend = 64'd50; bus.divisor = 64'd5;
    bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("no back-to-back", {62'b0, bus.busy, bus.req_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.dividend = 64'd77; bus.divisor = 64'd0;
    check("accepted after gap", {63'b0, bus.busy}, 64'd1);
    wait_resp(lat);
    check("divu 50/5 latency", 64'(lat), 64'd66);
    check("divu 50/5 result", bus.result, 64'd10);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Asynchronous reset mid-operation.
    start(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check("reset no resp", {63'b0, seen}, 64'd0);
    run("div 7/-2", OP_DIV, 1'b0, 64'd7, -64'sd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
